// File: rtl/registered_decoder_4_16.sv
// Registered 4:16 binary-to-one-hot decoder with valid/ready handshakes.
// A main register plus one skid entry keeps full rate under backpressure with a registered ready.
module registered_decoder_4_16 #(
    parameter int ACTIVE_LOW_OUTPUTS = 0
) (
    input  logic        Clock_In,
    input  logic        Reset_n_In,
    input  logic        Enable_In,
    input  logic [3:0]  Encoded_Value_In,
    input  logic        Encoded_Valid_In,
    output logic        Encoded_Ready_Out,
    output logic [15:0] Decoded_Value_Out,
    output logic        Decoded_Valid_Out,
    input  logic        Decoded_Ready_In
);

    // Encoding is {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_t;

    localparam logic [15:0] IDLE_VEC = (ACTIVE_LOW_OUTPUTS != 0) ? 16'hFFFF : 16'h0000;

    function automatic logic [15:0] decode_line(input logic [3:0] idx, input logic en);
        logic [15:0] line;
        line = en ? (16'h0001 << idx) : 16'h0000;
        return (ACTIVE_LOW_OUTPUTS != 0) ? ~line : line;
    endfunction

    buf_state_t  state_p1, state_nxt;
    logic        rdy_p1;
    logic [15:0] main_data_p1, main_data_nxt;
    logic [15:0] skid_data_p1, skid_data_nxt;
    logic [15:0] dec_vec_p0;
    logic        in_xfer;
    logic        out_xfer;

    // Stage p0: handshake qualification and decode of the offered index.
    assign in_xfer    = Encoded_Valid_In && rdy_p1;
    assign out_xfer   = state_p1[1] && Decoded_Ready_In;
    assign dec_vec_p0 = decode_line(Encoded_Value_In, Enable_In);

    always_comb begin
        state_nxt     = state_p1;
        main_data_nxt = main_data_p1;
        skid_data_nxt = skid_data_p1;
        case (state_p1)
            BUF_EMPTY: begin
                if (in_xfer) begin
                    main_data_nxt = dec_vec_p0;
                    state_nxt     = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_data_nxt = dec_vec_p0;
                end else if (in_xfer) begin
                    skid_data_nxt = dec_vec_p0;
                    state_nxt     = BUF_FULL;
                end else if (out_xfer) begin
                    state_nxt     = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (out_xfer) begin
                    main_data_nxt = skid_data_p1;
                    state_nxt     = BUF_ONE;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    // Stage p1: buffer state, registered ready and output register.
    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            state_p1     <= BUF_EMPTY;
            rdy_p1       <= 1'b0;
            main_data_p1 <= IDLE_VEC;
        end else begin
            state_p1     <= state_nxt;
            rdy_p1       <= (state_nxt != BUF_FULL);
            main_data_p1 <= main_data_nxt;
        end
    end

    // Skid data is qualified by the state flags, so it needs no reset.
    always_ff @(posedge Clock_In) begin
        skid_data_p1 <= skid_data_nxt;
    end

    assign Encoded_Ready_Out = rdy_p1;
    assign Decoded_Valid_Out = state_p1[1];
    assign Decoded_Value_Out = main_data_p1;

endmodule
